// File: rtl/mem_port_arbiter_if.sv
// Bundle between the arbiter, its two requesters (CPU sequencer, IOP data
// channel) and the memory array.
// Ports: per-requester req/we/addr/wdata in, gnt/rvalid out; shared rdata out;
//        memory side mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in.
// Bit mapping: machine addresses are numbered [15:31] and data [0:31] with the
// lowest index as MSB; here they are carried as [16:0] / [31:0], so machine
// bit 15 of an address is [16] and machine data bit 0 is [31].
interface mem_port_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [16:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;

    logic        iop_req;
    logic        iop_we;
    logic [16:0] iop_addr;
    logic [31:0] iop_wdata;
    logic        iop_gnt;
    logic        iop_rvalid;

    logic [31:0] rdata;

    logic        mem_en;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  iop_req, iop_we, iop_addr, iop_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, iop_gnt, iop_rvalid, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requesters plus memory array side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output iop_req, iop_we, iop_addr, iop_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, iop_gnt, iop_rvalid, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between CPU sequencer and IOP, IOP priority.
// Latency: gnt/mem_en one cycle after the accepting edge; read rvalid MEM_LATENCY+1 cycles after gnt.
// Backpressure: one transaction outstanding; requests are only sampled at accepting edges, so requesters hold req until gnt.
//
// Ports: clock, reset (async, active-high), bus (mem_port_arbiter_if.slave).
// Parameters: MEM_LATENCY (1..7) cycles in WAIT before read capture;
//             MAX_WAIT (1..15) lost arbitrations before the CPU is forced in.
// Optional feature: define MEM_ARB_FAIR_EN to enable the CPU starvation
// counter; without it arbitration is strict IOP priority.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int MAX_WAIT    = 4
) (
    input  logic                clock,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [2:0] LAT_C      = 3'(MEM_LATENCY);
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  lat_cnt;
    logic [2:0]  lat_cnt_nxt;

    logic        any_req;
    logic        win_iop;
    logic        force_cpu;
    logic        accept;     // this edge latches a new transaction
    logic        capture;    // this edge latches mem_rdata

    logic        own_iop;    // owner of the transaction in flight
    logic        we_q;
    logic [16:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        cpu_rv_q;
    logic        iop_rv_q;

    assign any_req = bus.cpu_req | bus.iop_req;

`ifdef MEM_ARB_FAIR_EN
    logic [3:0] starve_cnt;

    // CPU is forced in once it has lost MAX_WAIT arbitrations in a row.
    assign force_cpu = bus.cpu_req && (starve_cnt == MAX_WAIT_C);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (accept) begin
            if (!win_iop) begin
                starve_cnt <= 4'd0;
            end else if (bus.cpu_req && (starve_cnt != 4'hF)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`else
    logic [3:0] unused_max_wait;

    assign unused_max_wait = MAX_WAIT_C;
    assign force_cpu       = 1'b0;
`endif

    assign win_iop = bus.iop_req & ~force_cpu;

    // Next-state logic. The edge that completes a read is also an accepting
    // edge, so the next grant lands in the same cycle as the rvalid pulse.
    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        accept      = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_nxt = IDLE;
                end else begin
                    lat_cnt_nxt = LAT_C;
                    state_nxt   = WAIT;
                end
            end
            WAIT: begin
                lat_cnt_nxt = lat_cnt - 3'd1;
                if (lat_cnt == 3'd1) begin
                    capture = 1'b1;
                    if (any_req) begin
                        accept    = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            lat_cnt <= 3'd0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
        end
    end

    // Transaction and read-return registers. Requester inputs are only
    // looked at on an accepting edge; afterwards mem_* holds what was latched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            own_iop  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 17'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            cpu_rv_q <= 1'b0;
            iop_rv_q <= 1'b0;
        end else begin
            cpu_rv_q <= capture & ~own_iop;
            iop_rv_q <= capture &  own_iop;
            if (capture) begin
                rdata_q <= bus.mem_rdata;
            end
            if (accept) begin
                own_iop <= win_iop;
                we_q    <= win_iop ? bus.iop_we    : bus.cpu_we;
                addr_q  <= win_iop ? bus.iop_addr  : bus.cpu_addr;
                wdata_q <= win_iop ? bus.iop_wdata : bus.cpu_wdata;
            end
        end
    end

    assign bus.mem_en     = (state == ISSUE);
    assign bus.mem_we     = (state == ISSUE) & we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.cpu_gnt    = (state == ISSUE) & ~own_iop;
    assign bus.iop_gnt    = (state == ISSUE) &  own_iop;
    assign bus.cpu_rvalid = cpu_rv_q;
    assign bus.iop_rvalid = iop_rv_q;
    assign bus.rdata      = rdata_q;

endmodule
